// File: rtl/clk_tick_gen.sv
// clk_tick_gen: free-running display prescaler plus NUM_CH programmable
// single-cycle tick channels, all in the clk_i domain.
// Build option: define CLK_TICK_GEN_FAST_SIM_EN to shrink the display
// prescaler to 2 bits and the reset divisor to 4 for short simulations.
// Leave it undefined for synthesis.
module clk_tick_gen #(
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 27,
   parameter int SEL_W   = 1,
   parameter int DISP_W  = 20,
   parameter int DIV_RST = 100_000_000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] ch_en_i,
   input  logic              clr_i,
   input  logic              div_we_i,
   input  logic [SEL_W-1:0]  div_sel_i,
   input  logic [CNT_W-1:0]  div_data_i,
   output logic [NUM_CH-1:0] tick_o,
   output logic              disp_clk_o,
   output logic [1:0]        disp_sel_o
);

`ifdef CLK_TICK_GEN_FAST_SIM_EN
   localparam int PW     = 2;
   localparam int DIV_IV = 4;
`else
   localparam int PW     = DISP_W;
   localparam int DIV_IV = DIV_RST;
`endif

   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_IV);

   logic [PW-1:0]     pcnt_q, pcnt_d;
   logic [CNT_W-1:0]  div_q  [NUM_CH];
   logic [CNT_W-1:0]  div_d  [NUM_CH];
   logic [CNT_W-1:0]  cnt_q  [NUM_CH];
   logic [CNT_W-1:0]  cnt_d  [NUM_CH];
   logic [CNT_W-1:0]  lim    [NUM_CH];
   logic [NUM_CH-1:0] tick_q, tick_d;

   // Terminal count per channel; divisors 0 and 1 both give a limit of 0
   // so the channel ticks on every enabled edge.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         lim[i] = (div_q[i] == '0) ? '0 : div_q[i] - 1'b1;
      end
   end

   // Next-state for prescaler and channels; a write to a channel outranks
   // clr, and clr outranks the enable/count path.
   always_comb begin
      pcnt_d = pcnt_q + 1'b1;
      tick_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         div_d[i] = div_q[i];
         cnt_d[i] = cnt_q[i];
         if (div_we_i && (int'(div_sel_i) == i)) begin
            div_d[i] = div_data_i;
            cnt_d[i] = '0;
         end else if (clr_i) begin
            cnt_d[i] = '0;
         end else if (ch_en_i[i]) begin
            if (cnt_q[i] >= lim[i]) begin
               cnt_d[i]  = '0;
               tick_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pcnt_q <= '0;
         tick_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i] <= DIV_INIT;
            cnt_q[i] <= '0;
         end
      end else begin
         pcnt_q <= pcnt_d;
         tick_q <= tick_d;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i] <= div_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign tick_o     = tick_q;
   assign disp_clk_o = pcnt_q[PW-1];
   assign disp_sel_o = pcnt_q[PW-1 -: 2];

endmodule

// File: tb/tb_clk_tick_gen.sv
// Randomised and directed bench for clk_tick_gen against a counting model.
module tb_clk_tick_gen;

   localparam int NUM_CH  = 2;
   localparam int CNT_W   = 27;
   localparam int SEL_W   = 2;
   localparam int DISP_W  = 4;
   localparam int DIV_RST = 6;
`ifdef CLK_TICK_GEN_FAST_SIM_EN
   localparam int EPW  = 2;
   localparam int EDRS = 4;
`else
   localparam int EPW  = DISP_W;
   localparam int EDRS = DIV_RST;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] ch_en = '0;
   logic              clr = 1'b0;
   logic              div_we = 1'b0;
   logic [SEL_W-1:0]  div_sel = '0;
   logic [CNT_W-1:0]  div_data = '0;
   logic [NUM_CH-1:0] tick;
   logic              disp_clk;
   logic [1:0]        disp_sel;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: divisor, enabled edges elapsed in the current period, expected tick.
   int          md [NUM_CH];
   int          mp [NUM_CH];
   logic [NUM_CH-1:0] et;
   int          pc;

   clk_tick_gen #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W),
      .DISP_W(DISP_W), .DIV_RST(DIV_RST)
   ) dut (
      .clk_i(clk), .rst_i(rst), .ch_en_i(ch_en), .clr_i(clr),
      .div_we_i(div_we), .div_sel_i(div_sel), .div_data_i(div_data),
      .tick_o(tick), .disp_clk_o(disp_clk), .disp_sel_o(disp_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one edge, clock the DUT, then compare.
   task automatic step();
      for (int i = 0; i < NUM_CH; i++) begin
         int period;
         if (rst) begin
            md[i] = EDRS; mp[i] = 0; et[i] = 1'b0;
         end else if (div_we && int'(div_sel) == i) begin
            md[i] = int'(div_data); mp[i] = 0; et[i] = 1'b0;
         end else if (clr) begin
            mp[i] = 0; et[i] = 1'b0;
         end else if (!ch_en[i]) begin
            et[i] = 1'b0;
         end else begin
            period = (md[i] < 1) ? 1 : md[i];
            mp[i]++;
            if (mp[i] >= period) begin
               mp[i] = 0; et[i] = 1'b1;
            end else begin
               et[i] = 1'b0;
            end
         end
      end
      pc = rst ? 0 : (pc + 1) % (1 << EPW);
      @(posedge clk);
      #1;
      chk("tick", 32'(tick), 32'(et));
      chk("disp_sel", 32'(disp_sel), 32'((pc >> (EPW - 2)) % 4));
      chk("disp_clk", 32'(disp_clk), 32'((pc >> (EPW - 1)) % 2));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wr(input int sel, input int data, input logic with_clr);
      div_we = 1'b1; div_sel = SEL_W'(sel); div_data = CNT_W'(data); clr = with_clr;
      step();
      div_we = 1'b0; clr = 1'b0;
   endtask

   initial begin
      pc = 0;
      et = '0;
      for (int i = 0; i < NUM_CH; i++) begin md[i] = 0; mp[i] = 0; end
      rst = 1'b1;
      run(2);
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_disp_sel", 32'(disp_sel), 32'd0);
      rst = 1'b0;
      ch_en = 2'b11;
      run(3 * EDRS + 1);

      wr(0, 10, 1'b0);
      run(2);
      wr(1, 3, 1'b0);
      run(30);

      wr(0, 5, 1'b0);
      run(2);
      ch_en[0] = 1'b0;
      run(7);
      ch_en[0] = 1'b1;
      run(2);
      step();
      chk("resume_tick0", 32'(tick[0]), 32'd1);
      run(4);

      wr(0, 100, 1'b0);
      run(60);
      wr(0, 20, 1'b0);
      run(25);
      run(7);
      wr(0, 20, 1'b1);
      run(22);

      wr(1, 0, 1'b0);
      run(4);
      chk("div0_tick1", 32'(tick[1]), 32'd1);
      wr(1, 1, 1'b0);
      run(4);
      chk("div1_tick1", 32'(tick[1]), 32'd1);
      wr(1, 4, 1'b0);
      wr(3, 2, 1'b0);
      run(10);

      wr(0, 7, 1'b0);
      run(3);
      rst = 1'b1;
      step();
      chk("mid_rst_tick", 32'(tick), 32'd0);
      div_we = 1'b1; div_sel = '0; div_data = CNT_W'(2);
      step();
      div_we = 1'b0; rst = 1'b0;
      run(2 * EDRS + 1);

      for (int k = 0; k < 3000; k++) begin
         ch_en  = NUM_CH'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) ch_en = 2'b11;
         clr    = ($urandom_range(0, 40) == 0);
         div_we = ($urandom_range(0, 15) == 0);
         div_sel  = SEL_W'($urandom_range(0, 3));
         div_data = CNT_W'($urandom_range(0, 12));
         rst    = ($urandom_range(0, 300) == 0);
         step();
      end
      rst = 1'b0; clr = 1'b0; div_we = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
